// File: rtl/tx_parity_pkg.sv
// Shared constants for the TX frame builder: parity mode encodings and frame layout values.
package tx_parity_pkg;

    localparam int DATA_W = 8;
    localparam int FRAME_W = DATA_W + 3;

    localparam logic [1:0] PAR_NONE  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_SPACE = 2'b11;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic [FRAME_W-1:0] IDLE_FRAME = 11'h7FF;

    // Even parity of a data byte (XOR of all bits).
    function automatic logic even_parity8(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/tx_parity_parity_calc.sv
// Combinational parity-bit generator for one TX frame.
// With TX_PARITY_FORCE_ERR_EN defined, a force_err input inverts the parity bit for modes 01/10/11.
module parity_calc #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        mode,
`ifdef TX_PARITY_FORCE_ERR_EN
    input  logic              force_err,
`endif
    output logic              parity
);
    import tx_parity_pkg::*;

    logic xor_s;
    logic calc_s;

    assign xor_s = ^data;

    // Select the parity bit for the requested mode; mode 00 doubles as a second stop bit.
    always_comb begin
        calc_s = STOP_BIT;
        case (mode)
            PAR_NONE:  calc_s = STOP_BIT;
            PAR_ODD:   calc_s = ~xor_s;
            PAR_EVEN:  calc_s = xor_s;
            PAR_SPACE: calc_s = 1'b0;
            default:   calc_s = STOP_BIT;
        endcase
    end

`ifdef TX_PARITY_FORCE_ERR_EN
    // Deliberate error injection; the extra stop bit in mode 00 is never disturbed.
    always_comb begin
        parity = calc_s;
        if (force_err && (mode != PAR_NONE)) begin
            parity = ~calc_s;
        end else begin
            parity = calc_s;
        end
    end
`else
    assign parity = calc_s;
`endif

endmodule

// File: rtl/tx_parity.sv
// TX frame builder: registers {stop, parity, data, start} every cycle with one cycle of latency.
// Optional macro TX_PARITY_FORCE_ERR_EN adds i_Force_Err for parity error injection.
module tx_parity #(
    parameter int DATA_W = 8
) (
    input  logic              i_Pclk,
    input  logic              i_Rstn,
`ifdef TX_PARITY_FORCE_ERR_EN
    input  logic              i_Force_Err,
`endif
    input  logic [1:0]        i_Parity,
    input  logic [DATA_W-1:0] i_Data,
    output logic [DATA_W+2:0] o_Data
);
    import tx_parity_pkg::*;

    localparam int FRAME_BITS = DATA_W + 3;

    logic                  parity_s;
    logic [FRAME_BITS-1:0] frame_s;
    logic [FRAME_BITS-1:0] frame_r;

    parity_calc #(
        .DATA_W    (DATA_W)
    ) u_parity_calc (
        .data      (i_Data),
        .mode      (i_Parity),
`ifdef TX_PARITY_FORCE_ERR_EN
        .force_err (i_Force_Err),
`endif
        .parity    (parity_s)
    );

    // Bit 0 leaves the shift register first, so the start bit sits at the LSB.
    assign frame_s = {STOP_BIT, parity_s, i_Data, START_BIT};

    // Frame register; reset holds the line idle (all ones).
    always_ff @(posedge i_Pclk) begin
        if (!i_Rstn) begin
            frame_r <= {FRAME_BITS{1'b1}};
        end else begin
            frame_r <= frame_s;
        end
    end

    assign o_Data = frame_r;

endmodule

// File: tb/tb_tx_parity.sv
// Self-checking bench for tx_parity: scoreboard of expected frames, one task per scenario.
`timescale 1ns/1ps
module tb_tx_parity;

    logic        clk;
    logic        rstn;
    logic [1:0]  par;
    logic [7:0]  data;
    logic        ferr;
    logic [10:0] frame;

    int checks = 0;
    int failures = 0;
    logic [10:0] exp_q[$];

    tx_parity #(.DATA_W(8)) dut (
        .i_Pclk      (clk),
        .i_Rstn      (rstn),
`ifdef TX_PARITY_FORCE_ERR_EN
        .i_Force_Err (ferr),
`endif
        .i_Parity    (par),
        .i_Data      (data),
        .o_Data      (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: count ones rather than XOR-reduce.
    function automatic logic [10:0] model(input logic r, input logic [1:0] m,
                                          input logic [7:0] d, input logic fe);
        int ones;
        logic p;
        ones = 0;
        for (int i = 0; i < 8; i++) if (d[i]) ones++;
        case (m)
            2'b00:   p = 1'b1;
            2'b01:   p = (ones % 2 == 0) ? 1'b1 : 1'b0;
            2'b10:   p = (ones % 2 == 1) ? 1'b1 : 1'b0;
            default: p = 1'b0;
        endcase
`ifdef TX_PARITY_FORCE_ERR_EN
        if (fe && m != 2'b00) p = ~p;
`endif
        if (!r) return 11'h7FF;
        return {1'b1, p, d, 1'b0};
    endfunction

    // Drive inputs at the falling edge and queue the frame expected after the next rising edge.
    task automatic drive(input logic r, input logic [1:0] m, input logic [7:0] d, input logic fe);
        @(negedge clk);
        rstn = r; par = m; data = d; ferr = fe;
        exp_q.push_back(model(r, m, d, fe));
    endtask

    task automatic test_reset();
        logic [10:0] e;
        drive(1'b0, 2'b01, 8'hA5, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 2'b10, 8'h3C, 1'b1);
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (frame !== 11'h7FF || e !== 11'h7FF) begin
                failures++;
                $display("FAIL reset_idle[%0d] got=%h want=7ff", k, frame);
            end
        end
        // Out-of-order pops above are fine: both entries are idle frames.
        drive(1'b1, 2'b01, 8'h03, 1'b0);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if (frame !== 11'h606 || e !== 11'h606) begin
            failures++;
            $display("FAIL reset_release got=%h want=606", frame);
        end
    endtask

    task automatic test_modes();
        logic [1:0]  m_t[7]  = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b11, 2'b00};
        logic [7:0]  d_t[7]  = '{8'h03, 8'h07, 8'h03, 8'h07, 8'h03, 8'h07, 8'hFF};
        logic [10:0] x_t[7]  = '{11'h606, 11'h40E, 11'h406, 11'h60E, 11'h606, 11'h40E, 11'h7FE};
        logic [10:0] e;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, m_t[i], d_t[i], 1'b0);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (frame !== e || e !== x_t[i]) begin
                failures++;
                $display("FAIL mode_vec[%0d] got=%h want=%h", i, frame, x_t[i]);
            end
        end
    endtask

    task automatic test_latency();
        logic [10:0] e;
        drive(1'b1, 2'b01, 8'h03, 1'b0);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if (frame !== e) begin
            failures++;
            $display("FAIL latency_first got=%h want=%h", frame, e);
        end
        drive(1'b1, 2'b01, 8'h07, 1'b0);
        #2;
        checks++;
        if (frame !== 11'h606) begin
            failures++;
            $display("FAIL latency_hold got=%h want=606", frame);
        end
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if (frame !== 11'h40E || e !== 11'h40E) begin
            failures++;
            $display("FAIL latency_update got=%h want=40e", frame);
        end
        drive(1'b0, 2'b10, 8'h55, 1'b0);
        #2;
        checks++;
        if (frame !== 11'h40E) begin
            failures++;
            $display("FAIL reset_mid_hold got=%h want=40e", frame);
        end
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if (frame !== 11'h7FF || e !== 11'h7FF) begin
            failures++;
            $display("FAIL reset_mid got=%h want=7ff", frame);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] e;
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'b0);
            @(posedge clk); #1;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL b2b_queue_empty at %0d", i);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (frame !== e) begin
                    failures++;
                    $display("FAIL b2b[%0d] par=%b data=%h got=%h want=%h", i, par, data, frame, e);
                end
            end
        end
    endtask

`ifdef TX_PARITY_FORCE_ERR_EN
    task automatic test_force_err();
        logic [10:0] e;
        drive(1'b1, 2'b10, 8'h03, 1'b1);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if (frame !== 11'h606 || e !== 11'h606) begin
            failures++;
            $display("FAIL force_even got=%h want=606", frame);
        end
        drive(1'b1, 2'b00, 8'h03, 1'b1);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if (frame !== 11'h606 || e !== 11'h606) begin
            failures++;
            $display("FAIL force_none got=%h want=606", frame);
        end
    endtask
`endif

    initial begin
        rstn = 1'b0; par = 2'b00; data = 8'h00; ferr = 1'b0;
        test_reset();
        test_modes();
        test_latency();
        test_back_to_back();
`ifdef TX_PARITY_FORCE_ERR_EN
        test_force_err();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
